// File: rtl/mini_core_rmt_bridge.sv
// mini_core_rmt_bridge: steers core data-memory requests to local memory or to
// the remote fabric. Remote writes are posted through an in-order FIFO; remote
// reads go through the same FIFO and block the core until the response arrives
// or the response timer runs out.
module mini_core_rmt_bridge #(
    parameter int TILE_ID_W      = 8,
    parameter int OUT_FIFO_DEPTH = 4,
    parameter int RSP_TIMEOUT    = 1023
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic [TILE_ID_W-1:0] local_tile_id,

    input  logic [31:0]          DMemAddressQ103H,
    input  logic [31:0]          DMemWrDataQ103H,
    input  logic [3:0]           DMemByteEnQ103H,
    input  logic                 DMemWrEnQ103H,
    input  logic                 DMemRdEnQ103H,
    output logic                 DMemReadyQ103H,
    output logic [31:0]          DMemRdRspQ104H,

    output logic                 LocalReqValidQ103H,
    input  logic                 LocalReadyQ103H,
    input  logic [31:0]          LocalRdRspQ104H,

    output logic                 OutReqValid,
    output logic                 OutReqIsRd,
    output logic [31:0]          OutReqAddress,
    output logic [31:0]          OutReqData,
    output logic [3:0]           OutReqByteEn,
    input  logic                 OutReqReady,

    input  logic                 InRspValid,
    input  logic [31:0]          InRspData,

    output logic                 RmtTimeoutErr,
    output logic                 RmtBusy
);

    localparam int PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int TO_W  = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(OUT_FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LIMIT      = TO_W'(RSP_TIMEOUT);
    localparam logic [31:0]      TIMEOUT_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        DONE     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_LOCAL  = 2'd1,
        SRC_REMOTE = 2'd2
    } src_t;

    state_t state;
    state_t next_state;
    src_t   rsp_src;

    logic [TO_W-1:0]  to_cnt;
    logic [31:0]      rmt_data;
    logic             timeout_err;

    logic [31:0]      fifo_addr [OUT_FIFO_DEPTH];
    logic [31:0]      fifo_data [OUT_FIFO_DEPTH];
    logic [3:0]       fifo_be   [OUT_FIFO_DEPTH];
    logic             fifo_rd   [OUT_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    logic [TILE_ID_W-1:0] req_tile;
    logic req_valid;
    logic req_local;
    logic local_req;
    logic remote_req;
    logic remote_rd;
    logic remote_wr;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_space;
    logic push;
    logic ready;
    logic rsp_hit;
    logic timeout_hit;

    assign req_tile   = DMemAddressQ103H[31:32-TILE_ID_W];
    assign req_valid  = DMemRdEnQ103H | DMemWrEnQ103H;
    assign req_local  = (req_tile == local_tile_id) || (req_tile == '0);
    assign local_req  = req_valid & req_local;
    assign remote_req = req_valid & ~req_local;
    assign remote_rd  = remote_req & DMemRdEnQ103H;
    assign remote_wr  = remote_req & ~DMemRdEnQ103H;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign pop        = ~fifo_empty & OutReqReady;
    // A full FIFO can still take an entry in the same cycle the head leaves.
    assign push_space = ~fifo_full | pop;

    assign rsp_hit     = (state == WAIT_RSP) & InRspValid;
    assign timeout_hit = (state == WAIT_RSP) & ~InRspValid & (to_cnt == TO_LIMIT);

    // Remote read FSM state register.
    always_ff @(posedge Clock) begin
        if (Rst) state <= IDLE;
        else     state <= next_state;
    end

    // Remote read FSM next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!local_req && remote_rd && push_space) next_state = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (InRspValid || (to_cnt == TO_LIMIT)) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Core handshake, local steering and FIFO push decode.
    always_comb begin
        ready              = 1'b0;
        push               = 1'b0;
        LocalReqValidQ103H = 1'b0;
        if (local_req) begin
            LocalReqValidQ103H = 1'b1;
            ready              = LocalReadyQ103H;
        end else if (remote_req) begin
            case (state)
                IDLE: begin
                    push  = push_space;
                    ready = remote_wr & push_space;
                end
                WAIT_RSP: begin
                    ready = 1'b0;
                end
                DONE: begin
                    ready = remote_rd;
                end
                default: ready = 1'b0;
            endcase
        end
    end

    assign DMemReadyQ103H = ready;

    // Response timer counts cycles spent in WAIT_RSP, restarting on entry.
    always_ff @(posedge Clock) begin
        if (Rst)                    to_cnt <= '0;
        else if (state == WAIT_RSP) to_cnt <= to_cnt + TO_W'(1);
        else                        to_cnt <= '0;
    end

    // Capture remote read data, substituting a marker and flagging on timeout.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            rmt_data    <= '0;
            timeout_err <= 1'b0;
        end else if (rsp_hit) begin
            rmt_data    <= InRspData;
        end else if (timeout_hit) begin
            rmt_data    <= TIMEOUT_DATA;
            timeout_err <= 1'b1;
        end
    end

    // Remember where the read data for the just-accepted request comes from.
    always_ff @(posedge Clock) begin
        if (Rst)                            rsp_src <= SRC_NONE;
        else if (ready && DMemRdEnQ103H)    rsp_src <= local_req ? SRC_LOCAL : SRC_REMOTE;
        else                                rsp_src <= SRC_NONE;
    end

    // Read data mux driven by the registered source select.
    always_comb begin
        case (rsp_src)
            SRC_LOCAL:  DMemRdRspQ104H = LocalRdRspQ104H;
            SRC_REMOTE: DMemRdRspQ104H = rmt_data;
            default:    DMemRdRspQ104H = '0;
        endcase
    end

    // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; read entries carry zero data.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= DMemAddressQ103H;
            fifo_data[wr_ptr] <= DMemRdEnQ103H ? 32'h0 : DMemWrDataQ103H;
            fifo_be[wr_ptr]   <= DMemByteEnQ103H;
            fifo_rd[wr_ptr]   <= DMemRdEnQ103H;
        end
    end

    assign OutReqValid   = ~fifo_empty;
    assign OutReqIsRd    = fifo_rd[rd_ptr];
    assign OutReqAddress = fifo_addr[rd_ptr];
    assign OutReqData    = fifo_data[rd_ptr];
    assign OutReqByteEn  = fifo_be[rd_ptr];

    assign RmtTimeoutErr = timeout_err;
    assign RmtBusy       = ~fifo_empty | (state != IDLE);

endmodule
